vending_controller: RTL

Parametrised successor to the fixed 20-cent dispenser FSM. Consumes one-cycle coin strobes from the coin detector and accumulates credit in nickel units. Issues a single dispense pulse when credit reaches PRICE_UNITS and can pay out the excess as timed nickel-return pulses. Sits between the coin detector and the dispense/change actuators.

---
 rtl/vending_pkg.sv | 44 ++++
 rtl/change_pacer.sv | 39 +++
 rtl/vending_controller.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared types, coin values and the strobe decoder for vending_controller.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DISPENSE,
        CHANGE
    } vend_state_t;

    localparam int unsigned NICKEL_UNITS  = 1;
    localparam int unsigned DIME_UNITS    = 2;
    localparam int unsigned QUARTER_UNITS = 5;

    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic [2:0] units;
    } coin_t;

    // Exactly one strobe yields a valid coin; two or more flag an illegal combination.
    function automatic coin_t coin_value(input logic nickel, input logic dime,
                                         input logic quarter);
        coin_t c;
        c = '0;
        case ({nickel, dime, quarter})
            3'b000: c = '0;
            3'b100: begin
                c.valid = 1'b1;
                c.units = 3'(NICKEL_UNITS);
            end
            3'b010: begin
                c.valid = 1'b1;
                c.units = 3'(DIME_UNITS);
            end
            3'b001: begin
                c.valid = 1'b1;
                c.units = 3'(QUARTER_UNITS);
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/change_pacer.sv
// Gap counter and registered nickel-return pulse generator for the change payout.
module change_pacer #(
    parameter int unsigned CHANGE_GAP = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_pending,
    output logic o_fire,
    output logic o_pulse
);

    localparam int unsigned CNT_W = $clog2(CHANGE_GAP);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CHANGE_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;

    // The pulse register is set as the counter steps to 0, so the pulse is high while it reads 0.
    assign o_fire  = i_pending && !i_start && (r_cnt == CNT_ONE);
    assign o_pulse = r_pulse;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else if (i_start) begin
            r_cnt   <= RELOAD;
            r_pulse <= 1'b0;
        end else if (i_pending) begin
            r_pulse <= (r_cnt == CNT_ONE);
            r_cnt   <= (r_cnt == '0) ? RELOAD : r_cnt - CNT_ONE;
        end else begin
            r_pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/vending_controller.sv
// Coin-credit vending FSM with dispense and timed nickel change payout.
// Optional cancel/refund input enabled by defining VENDING_CANCEL_EN.
module vending_controller
    import vending_pkg::*;
#(
    parameter int unsigned PRICE_UNITS      = 4,
    parameter int unsigned MAX_CREDIT_UNITS = 24,
    parameter int unsigned CREDIT_W         = 5,
    parameter int unsigned AUTO_CHANGE      = 1,
    parameter int unsigned CHANGE_GAP       = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                nickel_det,
    input  logic                dime_det,
    input  logic                quarter_det,
`ifdef VENDING_CANCEL_EN
    input  logic                cancel,
`endif
    output logic                dispense,
    output logic                change_nickel,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [CREDIT_W:0]   MAX_L   = (CREDIT_W + 1)'(MAX_CREDIT_UNITS);
    localparam logic [CREDIT_W:0]   PRICE_L = (CREDIT_W + 1)'(PRICE_UNITS);
    localparam logic [CREDIT_W-1:0] PRICE_S = CREDIT_W'(PRICE_UNITS);
    localparam logic [CREDIT_W-1:0] ONE_S   = CREDIT_W'(1);

    vend_state_t         r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_dispense;
    logic                r_coin_reject;
    logic                r_busy;

    coin_t               w_coin;
    logic                w_any_strobe;
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W-1:0] w_after_sale;
    logic                w_start;
    logic                w_pending;
    logic                w_fire;
    logic                w_pulse;
`ifdef VENDING_CANCEL_EN
    logic                w_cancel_go;
`endif

    assign w_coin       = coin_value(nickel_det, dime_det, quarter_det);
    assign w_any_strobe = nickel_det | dime_det | quarter_det;
    assign w_sum        = {1'b0, r_credit} + (CREDIT_W + 1)'(w_coin.units);
    // Only used when PRICE <= sum <= MAX, so the narrow arithmetic cannot wrap.
    assign w_after_sale = r_credit + CREDIT_W'(w_coin.units) - PRICE_S;
    assign w_pending    = (r_state == CHANGE) && (r_credit != '0);

    always_comb begin
        w_start = 1'b0;
        if ((r_state == DISPENSE) && (AUTO_CHANGE != 0) && (r_credit != '0)) begin
            w_start = 1'b1;
        end
`ifdef VENDING_CANCEL_EN
        w_cancel_go = 1'b0;
        if ((r_state == IDLE) && cancel && (r_credit != '0)) begin
            w_cancel_go = 1'b1;
            w_start     = 1'b1;
        end
`endif
    end

    change_pacer #(
        .CHANGE_GAP(CHANGE_GAP)
    ) u_pacer (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_start),
        .i_pending(w_pending),
        .o_fire   (w_fire),
        .o_pulse  (w_pulse)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_credit      <= '0;
            r_dispense    <= 1'b0;
            r_coin_reject <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_dispense    <= 1'b0;
            r_coin_reject <= 1'b0;
            case (r_state)
                IDLE: begin
`ifdef VENDING_CANCEL_EN
                    if (w_cancel_go) begin
                        r_state       <= CHANGE;
                        r_busy        <= 1'b1;
                        r_coin_reject <= w_any_strobe;
                    end else
`endif
                    if (w_coin.illegal) begin
                        r_coin_reject <= 1'b1;
                    end else if (w_coin.valid) begin
                        if (w_sum > MAX_L) begin
                            r_coin_reject <= 1'b1;
                        end else if (w_sum >= PRICE_L) begin
                            r_credit   <= w_after_sale;
                            r_state    <= DISPENSE;
                            r_dispense <= 1'b1;
                            r_busy     <= 1'b1;
                        end else begin
                            r_credit <= w_sum[CREDIT_W-1:0];
                        end
                    end
                end
                DISPENSE: begin
                    r_coin_reject <= w_any_strobe;
                    if (w_start) begin
                        r_state <= CHANGE;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                CHANGE: begin
                    r_coin_reject <= w_any_strobe;
                    // Hold CHANGE through the last pulse cycle, then leave once credit is spent.
                    if (w_fire) begin
                        r_credit <= r_credit - ONE_S;
                    end else if (r_credit == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dispense      = r_dispense;
    assign change_nickel = w_pulse;
    assign coin_reject   = r_coin_reject;
    assign busy          = r_busy;
    assign credit        = r_credit;

endmodule
